multi_port_banked_sram: RTL and testbench
=========================================

// Module: multi_port_banked_sram
// PURPOSE
// - Behavioural on-chip SRAM with NUM_PORTS independent OBI slave ports over NUM_BANKS word-interleaved banks.
// - Serves several GPGPU cores or LSUs concurrently: each bank accepts one access per cycle.
// - Per-bank round-robin arbitration, byte-enabled writes, fixed read latency of 1 or 2 cycles, out-of-range error.
// PARAMETERS
// - MEM_SIZE_BYTE  32768  total capacity; power of 2, multiple of NUM_BANKS*DATA_WIDTH/8
// - DATA_WIDTH     32     word width in bits; 32 or 64
// - ADDR_WIDTH     32     OBI byte-address width
// - NUM_PORTS      2      OBI slave ports; 1..8
// - NUM_BANKS      4      interleaved banks; power of 2, 1..16
// - READ_LATENCY   1      cycles from grant to rvalid; 1 or 2 (2 adds an output register)
// PORTS
// - clk_i      in   1                      clock; all state on rising edge
// - rst_i      in   1                      asynchronous reset, active-high
// - req_i      in   [NUM_PORTS]            OBI request valid
// - we_i       in   [NUM_PORTS]            1 = write, 0 = read
// - be_i       in   [NUM_PORTS][DW/8]      byte enables; writes only
// - addr_i     in   [NUM_PORTS][AW]        byte address; low log2(DW/8) bits ignored
// - wdata_i    in   [NUM_PORTS][DW]        write data
// - gnt_o      out  [NUM_PORTS]            OBI grant; combinational in the req cycle
// - rvalid_o   out  [NUM_PORTS]            response valid, exactly READ_LATENCY cycles after gnt
// - rdata_o    out  [NUM_PORTS][DW]        read data; 0 for writes and errors
// - err_o      out  [NUM_PORTS]            response error, qualified by rvalid_o
// BEHAVIOUR
// - Decode: word = addr>>log2(DW/8); bank = word[log2(NUM_BANKS)-1:0]; row = remaining word bits.
// - Out of range: addr >= MEM_SIZE_BYTE. Request is still arbitrated and granted. No array access.
//   Response: err=1, rdata=0.
// - Arbitration: each bank has its own rr pointer, reset to 0. Among requesting ports, grant the first
//   port at or after the pointer. On a grant, pointer <= granted port + 1 (mod NUM_PORTS).
// - Ports hitting different banks are all granted in the same cycle. An ungranted port keeps req and
//   payload stable (OBI rule) and is retried the next cycle.
// - One outstanding response per port per cycle. No ordering issue: latency is fixed.
// - Write: bytes with be=1 are updated at the grant edge. be=0 is a legal no-op write that still
//   returns rvalid.
// - Read: returns array contents before any write in the same edge. A read in cycle N+1 sees the
//   write granted in cycle N.
// - READ_LATENCY=2: rvalid/rdata/err are registered once more. No bubbles; back-to-back grants
//   give back-to-back rvalids.
// - Reset (async assert, sync release): rvalid_o=0, err_o=0, rdata_o=0, rr pointers=0, pipeline
//   cleared. Array contents are NOT reset.
// - Reset mid-transaction: in-flight responses are dropped; no rvalid after reset release.
// - gnt_o=0 while rst_i=1.
// STRUCTURE
// - Package sram_pkg: word_t/be_t typedefs, clog2-derived constants BANK_IDX_W and ROW_W,
//   ERR_RDATA='0.
// - Sub-module mp_sram_bank: one behavioural bank with 1R/W port, byte-enable write and registered
//   read. Instantiated NUM_BANKS times.
// - Top-level logic: address decode, per-bank rr arbiters, port<->bank crossbar muxes, response
//   pipeline of READ_LATENCY stages holding port, bank, err and valid.
// TESTING
// - Setup for all cases: NUM_PORTS=2, NUM_BANKS=4, DW=32, READ_LATENCY=1 unless noted.
// - Single port: write 0xDEADBEEF @0x10 be=F, then read @0x10 -> gnt same cycle; rvalid 1 cycle
//   later; rdata=0xDEADBEEF, err=0.
// - Byte enables: write 0x11223344 @0x20, then write 0xAABBCCDD be=0b0101, then read
//   -> 0x11BB33DD.
// - Conflict: both ports read bank 0 (0x00, 0x10) and hold req
//   -> cycle0 gnt=01, cycle1 gnt=10, then ptr alternates; no starvation over 100 cycles.
// - Parallel: port0 @0x04 (bank1), port1 @0x08 (bank2) in the same cycle
//   -> gnt=11, both rvalid next cycle.
// - Error: read @MEM_SIZE_BYTE -> gnt=1, rvalid=1, err=1, rdata=0; array unchanged (check
//   readback of @0x0).
// - READ_LATENCY=2, back-to-back reads, with rst_i pulsed after 3 grants
//   -> rvalid 2 cycles after each gnt; no rvalid after reset release.

Source files
------------

// File: rtl/sram_pkg.sv
// Package sram_pkg: shared types, constants and helpers for multi_port_banked_sram.
// - word_t / be_t are sized for the widest supported word (64 bits); the top slices
//   them down to its DATA_WIDTH.
// - ERR_RDATA is the read data returned for writes and out-of-range accesses.
// - idx_width() gives a safe index width (never 0); rr_wrap() folds a rotated
//   round-robin index back into 0..n-1 without a divider.
package sram_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  typedef logic [MAX_DATA_WIDTH-1:0]   word_t;
  typedef logic [MAX_DATA_WIDTH/8-1:0] be_t;

  localparam word_t ERR_RDATA = '0;

  // Index width for a count of n items; at least 1 bit so single-entry cases stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Operand is always < 2*n (pointer + offset), so one conditional subtract suffices.
  function automatic int unsigned rr_wrap(input int unsigned a, input int unsigned n);
    return (a >= n) ? (a - n) : a;
  endfunction

endpackage

// File: rtl/mp_sram_bank.sv
// mp_sram_bank: one behavioural SRAM bank, single shared read/write port.
// Ports:
// - clk_i    clock
// - en_i     access enable for this cycle
// - we_i     1 = write, 0 = read
// - be_i     byte enables for writes
// - row_i    row index inside the bank
// - wdata_i  write data
// - rdata_o  registered read data (updated only by reads, holds otherwise)
// Contents are deliberately not reset.
module mp_sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROWS       = 2048,
  parameter int unsigned ROW_W      = 11
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ROW_W-1:0]        row_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [ROWS];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read data only changes on a read, so it reflects the array before this edge's write.
  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = mem_q[row_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
  end

  // Byte-enabled array write; be=0 leaves the row untouched.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (be_i[i]) begin
          mem_q[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_port_banked_sram.sv
// multi_port_banked_sram: NUM_PORTS OBI slave ports over NUM_BANKS word-interleaved banks.
// Ports (per OBI port p):
// - clk_i, rst_i            clock, asynchronous active-high reset
// - req_i/we_i/be_i         request valid, write flag, byte enables
// - addr_i/wdata_i          byte address (low byte-offset bits ignored), write data
// - gnt_o                   grant, combinational in the request cycle
// - rvalid_o/rdata_o/err_o  response READ_LATENCY cycles after grant; rdata=0 for writes/errors
// Each bank has its own round-robin pointer; ports hitting distinct banks are served together.
module multi_port_banked_sram
  import sram_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTE = 32768,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_PORTS-1:0]                   req_i,
  input  logic [NUM_PORTS-1:0]                   we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                   gnt_o,
  output logic [NUM_PORTS-1:0]                   rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]                   err_o
);

  localparam int unsigned BE_W       = DATA_WIDTH / 8;
  localparam int unsigned BYTE_OFF   = $clog2(BE_W);
  localparam int unsigned BANK_SH    = $clog2(NUM_BANKS);
  localparam int unsigned BANK_IDX_W = idx_width(NUM_BANKS);
  localparam int unsigned PORT_IDX_W = idx_width(NUM_PORTS);
  localparam int unsigned ROWS       = MEM_SIZE_BYTE / (NUM_BANKS * BE_W);
  localparam int unsigned ROW_W      = idx_width(ROWS);

  logic [NUM_PORTS-1:0]                 req_s;
  logic [NUM_PORTS-1:0]                 in_range_s;
  logic [NUM_PORTS-1:0][BANK_IDX_W-1:0] port_bank_s;
  logic [NUM_PORTS-1:0][ROW_W-1:0]      port_row_s;
  logic [NUM_PORTS-1:0]                 port_gnt_s;

  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_gnt_s;
  logic [NUM_BANKS-1:0][PORT_IDX_W-1:0] bank_sel_s;
  logic [NUM_BANKS-1:0]                 bank_hit_s;
  logic [NUM_BANKS-1:0][PORT_IDX_W-1:0] ptr_d, ptr_q;

  logic [NUM_BANKS-1:0]                 bank_en_s, bank_we_s;
  logic [NUM_BANKS-1:0][BE_W-1:0]       bank_be_s;
  logic [NUM_BANKS-1:0][ROW_W-1:0]      bank_row_s;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata_s, bank_rdata_s;

  logic [NUM_PORTS-1:0]                 rsp_valid_d, rsp_valid_q;
  logic [NUM_PORTS-1:0]                 rsp_err_d, rsp_err_q;
  logic [NUM_PORTS-1:0]                 rsp_read_d, rsp_read_q;
  logic [NUM_PORTS-1:0][BANK_IDX_W-1:0] rsp_bank_d, rsp_bank_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata_s;

  // Address decode; requests are masked while reset is held so nothing is granted.
  always_comb begin
    req_s       = rst_i ? '0 : req_i;
    in_range_s  = '0;
    port_bank_s = '0;
    port_row_s  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_range_s[p]  = ({32'd0, addr_i[p]} < {32'd0, ADDR_WIDTH'(MEM_SIZE_BYTE)});
      port_bank_s[p] = (NUM_BANKS > 32'd1) ? BANK_IDX_W'(addr_i[p] >> BYTE_OFF) : '0;
      port_row_s[p]  = ROW_W'(addr_i[p] >> (BYTE_OFF + BANK_SH));
    end
  end

  // Per-bank round-robin: first requester at or after the pointer wins, pointer moves past it.
  always_comb begin
    bank_gnt_s = '0;
    bank_sel_s = '0;
    bank_hit_s = '0;
    ptr_d      = ptr_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!bank_hit_s[b] &&
            req_s[rr_wrap(int'(ptr_q[b]) + k, NUM_PORTS)] &&
            (port_bank_s[rr_wrap(int'(ptr_q[b]) + k, NUM_PORTS)] == BANK_IDX_W'(b))) begin
          bank_hit_s[b] = 1'b1;
          bank_gnt_s[b][rr_wrap(int'(ptr_q[b]) + k, NUM_PORTS)] = 1'b1;
          bank_sel_s[b] = PORT_IDX_W'(rr_wrap(int'(ptr_q[b]) + k, NUM_PORTS));
          ptr_d[b]      = PORT_IDX_W'(rr_wrap(rr_wrap(int'(ptr_q[b]) + k, NUM_PORTS) + 1, NUM_PORTS));
        end else begin
          bank_hit_s[b] = bank_hit_s[b];
        end
      end
    end
  end

  // Port-side grant collection and bank-side request crossbar.
  // Out-of-range requests win arbitration like any other but never enable the array.
  always_comb begin
    port_gnt_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      port_gnt_s      = port_gnt_s | bank_gnt_s[b];
      bank_en_s[b]    = bank_hit_s[b] & in_range_s[bank_sel_s[b]];
      bank_we_s[b]    = we_i[bank_sel_s[b]];
      bank_be_s[b]    = be_i[bank_sel_s[b]];
      bank_row_s[b]   = port_row_s[bank_sel_s[b]];
      bank_wdata_s[b] = wdata_i[bank_sel_s[b]];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mp_sram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROWS       (ROWS),
      .ROW_W      (ROW_W)
    ) u_bank (
      .clk_i   (clk_i),
      .en_i    (bank_en_s[b]),
      .we_i    (bank_we_s[b]),
      .be_i    (bank_be_s[b]),
      .row_i   (bank_row_s[b]),
      .wdata_i (bank_wdata_s[b]),
      .rdata_o (bank_rdata_s[b])
    );
  end

  // First response stage: remembers which bank to read back and whether it is an error.
  always_comb begin
    rsp_valid_d = port_gnt_s;
    rsp_err_d   = port_gnt_s & ~in_range_s;
    rsp_read_d  = port_gnt_s & ~we_i;
    rsp_bank_d  = port_bank_s;
  end

  // Arbiter pointers and first response stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_read_q  <= '0;
      rsp_bank_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_read_q  <= rsp_read_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  // Return bank data only for successful reads.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsp_valid_q[p] && rsp_read_q[p] && !rsp_err_q[p]) begin
        rsp_rdata_s[p] = bank_rdata_s[rsp_bank_q[p]];
      end else begin
        rsp_rdata_s[p] = ERR_RDATA[DATA_WIDTH-1:0];
      end
    end
  end

  assign gnt_o = port_gnt_s;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [NUM_PORTS-1:0]                 out_valid_d, out_valid_q;
    logic [NUM_PORTS-1:0]                 out_err_d, out_err_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] out_rdata_d, out_rdata_q;

    // Second response stage inputs.
    always_comb begin
      out_valid_d = rsp_valid_q;
      out_err_d   = rsp_err_q;
      out_rdata_d = rsp_rdata_s;
    end

    // Extra output register; one slot per port keeps back-to-back responses bubble-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        out_valid_q <= '0;
        out_err_q   <= '0;
        out_rdata_q <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_err_q   <= out_err_d;
        out_rdata_q <= out_rdata_d;
      end
    end

    assign rvalid_o = out_valid_q;
    assign err_o    = out_err_q;
    assign rdata_o  = out_rdata_q;
  end else begin : g_lat1
    assign rvalid_o = rsp_valid_q;
    assign err_o    = rsp_err_q;
    assign rdata_o  = rsp_rdata_s;
  end

endmodule

// File: tb/tb_multi_port_banked_sram.sv
// Directed bench: dut1 uses the default configuration (READ_LATENCY=1),
// dut2 the same with READ_LATENCY=2 and its own reset.
module tb_multi_port_banked_sram;

  logic             clk;
  logic             rst, rst2;
  logic [1:0]       req, we, gnt, rvalid, err;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0]       req2, we2, gnt2, rvalid2, err2;
  logic [1:0][3:0]  be2;
  logic [1:0][31:0] addr2, wdata2, rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  multi_port_banked_sram dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  multi_port_banked_sram #(.READ_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .req_i(req2), .we_i(we2), .be_i(be2), .addr_i(addr2),
    .wdata_i(wdata2), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    req = 2'b00; we = 2'b00; be = '0; addr = '0; wdata = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    idle();
    req2 = 2'b00; we2 = 2'b00; be2 = '0; addr2 = '0; wdata2 = '0;
    @(negedge clk);
    req = 2'b11; addr[1] = 32'h4;
    #1;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", err); end
    n_checks++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++; if (rvalid2 !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid2: got %b want 00", rvalid2); end
    @(negedge clk); idle(); rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_release_rvalid: got %b want 00", rvalid); end
  endtask

  task automatic test_single_port();
    @(negedge clk);
    req = 2'b01; we = 2'b01; be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_wr_gnt: got %b want 01", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b01 || err !== 2'b00 || rdata[0] !== 32'h0)
      begin n_fail++; $display("FAIL single_wr_rsp: rvalid=%b err=%b rdata=%h want 01/00/0", rvalid, err, rdata[0]); end
    we = 2'b00;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_rd_gnt: got %b want 01", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b01 || err !== 2'b00 || rdata[0] !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL single_rd_rsp: rvalid=%b err=%b rdata=%h want 01/00/deadbeef", rvalid, err, rdata[0]); end
    idle();
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_idle_rvalid: got %b want 00", rvalid); end
  endtask

  task automatic test_byte_enables();
    @(negedge clk);
    req = 2'b01; we = 2'b01; be[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h11223344;
    @(negedge clk);
    be[0] = 4'b0101; wdata[0] = 32'hAABBCCDD;
    @(negedge clk);
    be[0] = 4'b0000; wdata[0] = 32'h55555555;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL be_zero_gnt: got %b want 01", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL be_zero_rvalid: got %b want 01", rvalid); end
    we = 2'b00;
    @(negedge clk);
    n_checks++; if (rdata[0] !== 32'h11BB33DD)
      begin n_fail++; $display("FAIL be_merge: got %h want 11bb33dd", rdata[0]); end
    idle();
  endtask

  task automatic test_conflict();
    int g0 = 0;
    int g1 = 0;
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    pulse_reset();
    req = 2'b11; we = 2'b00; addr[0] = 32'h00; addr[1] = 32'h10;
    prev_gnt = 2'b00;
    for (int k = 0; k < 100; k++) begin
      #1;
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (gnt !== exp_gnt)
        begin n_fail++; $display("FAIL conflict_gnt[%0d]: got %b want %b", k, gnt, exp_gnt); end
      if (gnt[0]) g0++;
      if (gnt[1]) g1++;
      @(negedge clk);
      n_checks++; if (rvalid !== exp_gnt)
        begin n_fail++; $display("FAIL conflict_rvalid[%0d]: got %b want %b", k, rvalid, exp_gnt); end
      prev_gnt = exp_gnt;
    end
    idle();
    n_checks++; if (g0 != 50 || g1 != 50)
      begin n_fail++; $display("FAIL conflict_fairness: got %0d/%0d want 50/50 (last %b)", g0, g1, prev_gnt); end
  endtask

  task automatic test_parallel();
    @(negedge clk);
    req = 2'b11; we = 2'b11; be[0] = 4'hF; be[1] = 4'hF;
    addr[0] = 32'h04; addr[1] = 32'h08; wdata[0] = 32'hCAFE0001; wdata[1] = 32'hCAFE0002;
    #1;
    n_checks++; if (gnt !== 2'b11) begin n_fail++; $display("FAIL parallel_wr_gnt: got %b want 11", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b11) begin n_fail++; $display("FAIL parallel_wr_rvalid: got %b want 11", rvalid); end
    we = 2'b00;
    #1;
    n_checks++; if (gnt !== 2'b11) begin n_fail++; $display("FAIL parallel_rd_gnt: got %b want 11", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b11 || rdata[0] !== 32'hCAFE0001 || rdata[1] !== 32'hCAFE0002)
      begin n_fail++; $display("FAIL parallel_rd: rvalid=%b rdata0=%h rdata1=%h want 11/cafe0001/cafe0002", rvalid, rdata[0], rdata[1]); end
    idle();
  endtask

  task automatic test_error();
    @(negedge clk);
    req = 2'b01; we = 2'b01; be[0] = 4'hF; addr[0] = 32'h0; wdata[0] = 32'h12345678;
    @(negedge clk);
    addr[0] = 32'h8000; wdata[0] = 32'hFFFFFFFF;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL err_wr_gnt: got %b want 01", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b01 || err !== 2'b01)
      begin n_fail++; $display("FAIL err_wr_rsp: rvalid=%b err=%b want 01/01", rvalid, err); end
    we = 2'b00;
    #1;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL err_rd_gnt: got %b want 01", gnt); end
    @(negedge clk);
    n_checks++; if (rvalid !== 2'b01 || err !== 2'b01 || rdata[0] !== 32'h0)
      begin n_fail++; $display("FAIL err_rd_rsp: rvalid=%b err=%b rdata=%h want 01/01/0", rvalid, err, rdata[0]); end
    addr[0] = 32'h0;
    @(negedge clk);
    n_checks++; if (err !== 2'b00 || rdata[0] !== 32'h12345678)
      begin n_fail++; $display("FAIL err_array_intact: err=%b rdata=%h want 00/12345678", err, rdata[0]); end
    idle();
  endtask

  task automatic test_back_to_back_lat2();
    @(negedge clk);
    req2 = 2'b01; we2 = 2'b01; be2[0] = 4'hF; addr2[0] = 32'h0; wdata2[0] = 32'hA0A00000;
    @(negedge clk); addr2[0] = 32'h4; wdata2[0] = 32'hA0A00001;
    @(negedge clk); addr2[0] = 32'h8; wdata2[0] = 32'hA0A00002;
    @(negedge clk); req2 = 2'b00; we2 = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b00) begin n_fail++; $display("FAIL lat2_idle: got %b want 00", rvalid2); end
    req2 = 2'b01; addr2[0] = 32'h0;
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_fail++; $display("FAIL lat2_gnt0: got %b want 01", gnt2); end
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b00) begin n_fail++; $display("FAIL lat2_early: got %b want 00", rvalid2); end
    addr2[0] = 32'h4;
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_fail++; $display("FAIL lat2_gnt1: got %b want 01", gnt2); end
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b01 || rdata2[0] !== 32'hA0A00000)
      begin n_fail++; $display("FAIL lat2_rsp0: rvalid=%b rdata=%h want 01/a0a00000", rvalid2, rdata2[0]); end
    addr2[0] = 32'h8;
    #1;
    n_checks++; if (gnt2 !== 2'b01) begin n_fail++; $display("FAIL lat2_gnt2: got %b want 01", gnt2); end
    @(negedge clk);
    n_checks++; if (rvalid2 !== 2'b01 || rdata2[0] !== 32'hA0A00001)
      begin n_fail++; $display("FAIL lat2_rsp1: rvalid=%b rdata=%h want 01/a0a00001", rvalid2, rdata2[0]); end
    rst2 = 1'b1;
    #1;
    n_checks++; if (rvalid2 !== 2'b00 || gnt2 !== 2'b00)
      begin n_fail++; $display("FAIL lat2_in_reset: rvalid=%b gnt=%b want 00/00", rvalid2, gnt2); end
    @(negedge clk);
    rst2 = 1'b0; req2 = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (rvalid2 !== 2'b00)
        begin n_fail++; $display("FAIL lat2_after_reset[%0d]: got %b want 00", k, rvalid2); end
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_byte_enables();
    test_conflict();
    test_parallel();
    test_error();
    test_back_to_back_lat2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
